// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 16-channel TDM link (rx demux and tx select generator).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdm_pkg;

  localparam int TDM_N_CH  = 16;
  localparam int TDM_CNT_W = 4;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_16_if.sv
// Serial-in / parallel-out bundle between a TDM line driver and the demux.
// Latency: n/a (wiring only).
// Backpressure: none; en is a slot strobe, a low en stalls the receiver.
interface tdm_demux_16_if
  import tdm_pkg::*;
#(
  parameter int N_CH  = TDM_N_CH,
  parameter int CNT_W = $clog2(N_CH)
) ();

  logic             en;
  logic             din;
  logic             fsync;
  logic [N_CH-1:0]  dout;
  logic             frame_valid;
  logic [CNT_W-1:0] slot;
  logic             locked;
  logic             sync_err;

  modport master (
    output en, din, fsync,
    input  dout, frame_valid, slot, locked, sync_err
  );

  modport slave (
    input  en, din, fsync,
    output dout, frame_valid, slot, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear, load-to-1 and increment, wraps naturally at 2**CNT_W.
// Latency: 1 cycle, registered output.
// Backpressure: holds its value whenever no control input is asserted.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int CNT_W = TDM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load1,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Clear beats load-to-1, which beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux_16.sv
// Serial TDM receiver: locks to fsync, deserialises N_CH slots, emits one parallel word per frame.
// Latency: dout/frame_valid visible the cycle after the slot N_CH-1 edge (N_CH cycles plus stalls from slot 0).
// Backpressure: en=0 freezes state, counter and shadow; pulses are low on stalled cycles.
module tdm_demux_16
  import tdm_pkg::*;
#(
  parameter int N_CH  = TDM_N_CH,
  parameter int CNT_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  tdm_demux_16_if.slave   bus
);

  tdm_state_e       state_q, state_d;
  logic [CNT_W-1:0] slot;
  logic             cnt_inc, cnt_load1, cnt_clr;
  logic             sh_wr;
  logic [CNT_W-1:0] sh_idx;
  logic             frame_done;
  logic             err;

  // Slot N_CH-1 goes straight from din into dout, so the shadow only needs N_CH-1 bits.
  logic [N_CH-2:0]  shadow_q;
  logic [N_CH-1:0]  dout_q;
  logic             frame_valid_q;
  logic             sync_err_q;

  tdm_slot_counter #(.CNT_W(CNT_W)) u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .cnt   (slot)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus counter/shadow/output control, evaluated only on slot strobes.
  always_comb begin
    state_d    = state_q;
    cnt_inc    = 1'b0;
    cnt_load1  = 1'b0;
    cnt_clr    = 1'b0;
    sh_wr      = 1'b0;
    sh_idx     = slot;
    frame_done = 1'b0;
    err        = 1'b0;
    if (bus.en) begin
      case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            sh_wr     = 1'b1;
            sh_idx    = '0;
            cnt_load1 = 1'b1;
            state_d   = LOCK;
          end
        end
        LOCK: begin
          if (bus.fsync) begin
            // Frame start; an fsync anywhere but slot 0 abandons the partial frame.
            sh_wr     = 1'b1;
            sh_idx    = '0;
            cnt_load1 = 1'b1;
            err       = (slot != '0);
          end else if (slot == '0) begin
            // Expected fsync never came: drop the bit and re-acquire.
            err     = 1'b1;
            cnt_clr = 1'b1;
            state_d = HUNT;
          end else begin
            cnt_inc    = 1'b1;
            frame_done = (slot == CNT_W'(N_CH - 1));
            sh_wr      = !frame_done;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Shadow capture, frame output register and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= frame_done;
      sync_err_q    <= err;
      if (sh_wr) begin
        shadow_q[sh_idx] <= bus.din;
      end
      if (frame_done) begin
        dout_q <= {bus.din, shadow_q};
      end
    end
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.slot        = slot;
  assign bus.locked      = (state_q == LOCK);
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_16.sv
// Randomised and directed bench for tdm_demux_16 against a queue-based frame model.
// Latency: n/a.
// Backpressure: en is dropped at random and in a directed stall scenario.
module tb_tdm_demux_16;
  import tdm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tdm_demux_16_if #(.N_CH(16)) bus ();

  tdm_demux_16 #(.N_CH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bits received since the last frame start are kept in a queue.
  bit          m_lock;
  bit          m_q[$];
  logic [15:0] m_dout;
  bit          m_fv;
  bit          m_err;

  function automatic void model_reset();
    m_lock = 1'b0;
    m_q.delete();
    m_dout = '0;
    m_fv   = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit d, input bit fs);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (!en) return;
    if (fs) begin
      if (m_lock && m_q.size() != 0) m_err = 1'b1;
      m_lock = 1'b1;
      m_q.delete();
      m_q.push_back(d);
    end else if (m_lock) begin
      if (m_q.size() == 0) begin
        m_err  = 1'b1;
        m_lock = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 16) begin
          for (int i = 0; i < 16; i++) m_dout[i] = m_q[i];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
  endfunction

  function automatic logic [22:0] exp_vec();
    return {m_dout, m_fv, 4'(m_q.size()), m_lock, m_err};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {bus.dout, bus.frame_valid, bus.slot, bus.locked, bus.sync_err};
  endfunction

  // One slot strobe cycle; returns 1 ns after the edge with the model advanced.
  task automatic step(input bit en, input bit d, input bit fs);
    bus.en    = en;
    bus.din   = d;
    bus.fsync = fs;
    @(posedge clk);
    model_step(en, d, fs);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.din = 1'b0; bus.fsync = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 23'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), 23'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_frame();
    logic [15:0] w = 16'hA5C3;
    int fv_cnt = 0, fv_at = -1, err_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, w[i], i == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clean_cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (bus.frame_valid) begin fv_cnt++; fv_at = i + 1; end
      if (bus.sync_err) err_cnt++;
    end
    checks++;
    if (bus.dout !== 16'hA5C3 || fv_cnt != 1 || fv_at != 16 || err_cnt != 0) begin
      errors++;
      $display("FAIL clean_frame: dout %h fv_cnt %0d fv_at %0d errs %0d want A5C3 1 16 0",
               bus.dout, fv_cnt, fv_at, err_cnt);
    end
  endtask

  task automatic test_stall();
    logic [15:0] w = 16'hA5C3;
    int n = 0, fv_at = -1, fv_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, w[i], i == 0);
      n++;
      if (bus.frame_valid) begin fv_cnt++; fv_at = n; end
      if (i == 6) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b0, 1'($urandom), 1'($urandom));
          n++;
          checks++;
          if (bus.slot !== 4'd7 || bus.frame_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stall_hold %0d: slot %0d fv %b vec %h want slot 7 vec %h",
                     s, bus.slot, bus.frame_valid, dut_vec(), exp_vec());
          end
        end
      end
    end
    checks++;
    if (bus.dout !== 16'hA5C3 || fv_cnt != 1 || fv_at != 19) begin
      errors++;
      $display("FAIL stall_frame: dout %h fv_cnt %0d fv_at %0d want A5C3 1 19", bus.dout, fv_cnt, fv_at);
    end
  endtask

  task automatic test_early_sync();
    logic [15:0] w = 16'h1234;
    int fv_cnt = 0, fv_at = -1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'($urandom), i == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL early_pre %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, w[i], i == 0);
      if (i == 0) begin
        checks++;
        if (bus.sync_err !== 1'b1 || bus.slot !== 4'd1 || bus.locked !== 1'b1) begin
          errors++;
          $display("FAIL early_err: sync_err %b slot %0d locked %b want 1 1 1",
                   bus.sync_err, bus.slot, bus.locked);
        end
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL early_cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (bus.frame_valid) begin fv_cnt++; fv_at = i + 1; end
    end
    checks++;
    if (bus.dout !== 16'h1234 || fv_cnt != 1 || fv_at != 16) begin
      errors++;
      $display("FAIL early_frame: dout %h fv_cnt %0d fv_at %0d want 1234 1 16", bus.dout, fv_cnt, fv_at);
    end
  endtask

  task automatic test_missing_sync();
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.dout !== 16'h1234 || bus.slot !== 4'd0) begin
      errors++;
      $display("FAIL missing_err: err %b locked %b dout %h slot %0d want 1 0 1234 0",
               bus.sync_err, bus.locked, bus.dout, bus.slot);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom), 1'($urandom), 1'b0);
      checks++;
      if (bus.locked !== 1'b0 || bus.slot !== 4'd0 || bus.frame_valid !== 1'b0 ||
          bus.sync_err !== 1'b0 || bus.dout !== 16'h1234) begin
        errors++;
        $display("FAIL missing_hunt %0d: got %h want dout 1234 idle", i, dut_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w = {16'h8000, 16'h0001};
    int fv_at[$];
    for (int i = 0; i < 32; i++) begin
      step(1'b1, w[i], i == 0 || i == 16);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (bus.frame_valid) fv_at.push_back(i + 1);
      if (i >= 15 && i < 31) begin
        checks++;
        if (bus.dout !== 16'h0001) begin
          errors++;
          $display("FAIL b2b_hold %0d: dout %h want 0001", i, bus.dout);
        end
      end
    end
    checks++;
    if (fv_at.size() != 2 || bus.dout !== 16'h8000) begin
      errors++;
      $display("FAIL b2b_pulses: count %0d dout %h want 2 8000", fv_at.size(), bus.dout);
    end else if (fv_at[1] - fv_at[0] != 16) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 16", fv_at[1] - fv_at[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w = 16'hFFFF;
    for (int i = 0; i < 9; i++) step(1'b1, 1'($urandom), i == 0);
    checks++;
    if (bus.slot !== 4'd9) begin
      errors++;
      $display("FAIL midrst_slot: got %0d want 9", bus.slot);
    end
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (dut_vec() !== 23'h0) begin
      errors++;
      $display("FAIL midrst_clear: got %h want %h", dut_vec(), 23'h0);
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, w[i], i == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.dout !== 16'hFFFF) begin
      errors++;
      $display("FAIL midrst_frame: dout %h want FFFF", bus.dout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit en = ($urandom_range(0, 4) != 0);
      bit fs = (m_q.size() == 0 && $urandom_range(0, 9) != 0) || ($urandom_range(0, 29) == 0);
      step(en, 1'($urandom), fs);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_stall();
    test_early_sync();
    test_missing_sync();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_16.md
# tdm_demux_16

Receive-end time-division demultiplexer for the 16-channel serial link whose transmit side is driven by `mux_16x1` with a counter on its selects. It tracks slot position from a frame-sync strobe, routes each incoming serial bit to its channel, and presents all channels as a parallel word once per frame. It also flags sync loss.

## Interface
- `N_CH`, default 16: channels per frame. Must be a power of two, at least 2.
- `CNT_W`, default `$clog2(N_CH)`: slot counter width. Derived; do not override.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  slot strobe. A bit is sampled only on edges where `en`=1. When `en`=0 the block stalls.
- `din`  in  1  serial data bit for the current slot.
- `fsync`  in  1  high together with the slot-0 bit of each frame. Ignored when `en`=0.
- `dout`  out  N_CH  last complete frame. Bit k holds slot k.
- `frame_valid`  out  1  one-cycle pulse when `dout` is updated.
- `slot`  out  CNT_W  index of the next slot expected.
- `locked`  out  1  high while in LOCK.
- `sync_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- States: HUNT and LOCK. Reset state is HUNT.
- Reset values: `dout`=0, `frame_valid`=0, `slot`=0, `locked`=0, `sync_err`=0. Shadow register is cleared.
- HUNT:
  - `din` is ignored until `fsync`=1 and `en`=1.
  - On that edge: shadow[0]<=`din`, `slot`<=1, go to LOCK.
- LOCK, on each edge with `en`=1, with `slot`=k:
  - k≠0 and `fsync`=0: shadow[k]<=`din`, then `slot`<=k+1 (wraps N_CH-1→0).
  - k=N_CH-1: `dout`<={`din`, shadow[N_CH-2:0]}, `frame_valid`<=1, `slot`<=0.
  - k=0 and `fsync`=1: start a new frame. shadow[0]<=`din`, `slot`<=1.
  - k≠0 and `fsync`=1 (early sync): `sync_err`<=1. The partial frame is discarded and no `frame_valid` is issued. shadow[0]<=`din`, `slot`<=1, stay in LOCK.
  - k=0 and `fsync`=0 (missing sync): `sync_err`<=1, go to HUNT, `slot`<=0, bit dropped.
- `dout` holds its value between frames and through HUNT.
- `en`=0: no state, counter or shadow changes. `frame_valid` and `sync_err` are 0.
- Asserting `rst_n` mid-frame clears everything immediately. The partial frame is lost and no pulse is emitted.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `dout` and `frame_valid` update on the same edge that samples slot N_CH-1. Both are visible in the following cycle.
- With `en` held high, `frame_valid` pulses every N_CH cycles.
- Latency from the slot-0 edge to `frame_valid` high = N_CH cycles plus the number of stall cycles.
- `sync_err` asserts in the cycle after the offending edge. It lasts exactly one cycle.
- `locked` rises the cycle after the HUNT→LOCK edge and falls the cycle after a missing-sync edge.

## Structure
- Shared package `tdm_pkg`:
  - `TDM_N_CH`=16
  - `TDM_CNT_W`=4
  - state enum `tdm_state_e` {HUNT, LOCK}
- The transmit-side counter will reuse the package constants.
- One sub-module, `tdm_slot_counter`:
  - CNT_W-bit counter with enable, synchronous load-to-1, and clear.
  - Asynchronous active-low reset.
  - Shared later with the transmitter's select generator.
- The top level holds the FSM, the shadow register and the output register.

## Test plan
- Clean frame: `en`=1, `fsync` on the first bit, bits of 16'hA5C3 sent LSB first. Expect `dout`=16'hA5C3, one `frame_valid` pulse 16 cycles after the first bit, `sync_err` never high.
- Stall: same frame with `en`=0 for 3 cycles after slot 6. Expect `dout`=16'hA5C3 and `frame_valid` 3 cycles later than in the clean-frame case. `slot` holds at 7 during the stall.
- Early sync: locked, `fsync` at slot 7 with payload 16'h1234 starting there. Expect a `sync_err` pulse and no `frame_valid` for the aborted frame. Then `dout`=16'h1234 16 cycles after the early sync.
- Missing sync: locked, `fsync`=0 at slot 0. Expect a `sync_err` pulse, `locked`=0, and `dout` unchanged. Later bits are ignored until the next `fsync`.
- Back-to-back frames: 16'h0001 then 16'h8000 with continuous `en`. Expect two `frame_valid` pulses 16 cycles apart, and `dout`=16'h0001 held between them.
- Reset mid-frame: drop `rst_n` at slot 9. Expect all outputs 0 immediately. After release, the next `fsync` frame 16'hFFFF gives `dout`=16'hFFFF.
